mux_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 16-bit datapath lane (the 4:1 input mux feeding the block-multiply MAC) between four block-operand requesters.
- Replaces free-running mux auto-select with valid/ready handshaking and fixed-length bursts per grant.
- Drives the mux select and registers the selected word, with source tag, toward the downstream consumer.

---
 rtl/mux_sched_defs_pkg.sv | 14 +
 rtl/mux_rr_scheduler_pick.sv | 28 ++
 rtl/mux_rr_scheduler.sv | 133 +++++++++++++
 tb/tb_mux_rr_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mux_sched_defs_pkg.sv
// Shared definitions for the round-robin lane scheduler: state encoding,
// requester count and the default word width used by the mux datapath.
package mux_sched_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int unsigned SEL_W      = 2;
  localparam int unsigned N_REQ      = 4;
  localparam int unsigned DATA_W_DEF = 16;

endpackage

// File: rtl/mux_rr_scheduler_pick.sv
// Rotating-priority encoder: picks the first valid requester after last_grant,
// searching last_grant+1 .. last_grant+4 modulo 4.
module rr_pick_4
  import mux_sched_defs::*;
(
  input  logic [N_REQ-1:0] req_valid,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last_grant + SEL_W'(k);
      if (req_valid[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one DATA_W lane between four requesters with
// valid/ready handshakes and bursts of up to BURST_LEN beats per grant.
module mux_rr_scheduler
  import mux_sched_defs::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [SEL_W-1:0]          select,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    select_q, select_d;
  logic [SEL_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_src_q, out_src_d;

  logic [DATA_W-1:0]   words [N_REQ];
  logic [SEL_W-1:0]    pick;
  logic                any;
  logic                lane_ready;
  logic                accept;
  logic                drain;

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick_4 u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .pick       (pick),
    .any        (any)
  );

  assign lane_ready = (state_q == ST_GRANT) && (!out_valid_q || out_ready);
  assign accept     = lane_ready && req_valid[select_q];
  assign drain      = out_valid_q && out_ready;

  // State register, including the datapath flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      select_q     <= '0;
      last_grant_q <= SEL_W'(N_REQ - 1);
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;

    if (drain) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = words[select_q];
      out_src_d   = select_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d    = ST_GRANT;
          select_d   = pick;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d      = ST_IDLE;
            last_grant_d = select_q;
          end
        end else if (!req_valid[select_q]) begin
          // Requester dropped out: release early so others are not starved.
          state_d      = ST_IDLE;
          last_grant_d = select_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; req_ready follows out_ready combinationally.
  always_comb begin
    req_ready = '0;
    if (lane_ready) begin
      req_ready[select_q] = 1'b1;
    end
    busy      = (state_q == ST_GRANT);
    select    = select_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_src   = out_src_q;
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Randomized bench for mux_rr_scheduler: a BURST_LEN=4 and a BURST_LEN=1 build
// share stimulus and are each compared every cycle against a transaction model.
module tb_mux_rr_scheduler;

  localparam int DW     = 16;
  localparam int NCYC   = 3000;

  logic          clock;
  logic          reset;
  logic [3:0]    req_valid;
  logic [4*DW-1:0] req_data;
  logic          out_ready;

  logic [3:0]    rr   [2];
  logic [1:0]    sel  [2];
  logic [DW-1:0] od   [2];
  logic [1:0]    os   [2];
  logic          ov   [2];
  logic          bz   [2];

  mux_rr_scheduler #(.DATA_W(DW), .BURST_LEN(4), .CNT_W(4)) dut_b4 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr[0]), .select(sel[0]), .out_data(od[0]), .out_src(os[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0])
  );

  mux_rr_scheduler #(.DATA_W(DW), .BURST_LEN(1), .CNT_W(4)) dut_b1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr[1]), .select(sel[1]), .out_data(od[1]), .out_src(os[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: who holds the lane, how many beats taken, and the output word.
  bit          m_granted [2];
  int          m_owner   [2];
  int          m_prev    [2];
  int          m_taken   [2];
  bit          m_ov      [2];
  logic [DW-1:0] m_od    [2];
  int          m_os      [2];
  logic [DW-1:0] words   [4];

  function automatic int burst_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_granted[d] = 1'b0;
      m_owner[d]   = 0;
      m_prev[d]    = 3;
      m_taken[d]   = 0;
      m_ov[d]      = 1'b0;
      m_od[d]      = '0;
      m_os[d]      = 0;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_rr;
    for (int d = 0; d < 2; d++) begin
      exp_rr = 4'b0000;
      if (m_granted[d] && (!m_ov[d] || out_ready)) exp_rr[m_owner[d]] = 1'b1;
      check_eq($sformatf("req_ready[%0d]", d), 32'(rr[d]), 32'(exp_rr));
      check_eq($sformatf("select[%0d]", d),    32'(sel[d]), 32'(m_owner[d]));
      check_eq($sformatf("busy[%0d]", d),      32'(bz[d]), 32'(m_granted[d]));
      check_eq($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(m_ov[d]));
      check_eq($sformatf("out_data[%0d]", d),  32'(od[d]), 32'(m_od[d]));
      check_eq($sformatf("out_src[%0d]", d),   32'(os[d]), 32'(m_os[d]));
    end
  endtask

  task automatic model_advance();
    bit acc;
    int cand;
    for (int d = 0; d < 2; d++) begin
      acc = m_granted[d] && req_valid[m_owner[d]] && (!m_ov[d] || out_ready);
      if (m_ov[d] && out_ready) m_ov[d] = 1'b0;
      if (acc) begin
        m_ov[d] = 1'b1;
        m_od[d] = words[m_owner[d]];
        m_os[d] = m_owner[d];
      end
      if (!m_granted[d]) begin
        for (int k = 4; k >= 1; k--) begin
          cand = (m_prev[d] + k) % 4;
          if (req_valid[cand]) begin
            m_granted[d] = 1'b1;
            m_owner[d]   = cand;
            m_taken[d]   = 0;
          end
        end
      end else if (acc) begin
        m_taken[d]++;
        if (m_taken[d] == burst_of(d)) begin
          m_granted[d] = 1'b0;
          m_prev[d]    = m_owner[d];
        end
      end else if (!req_valid[m_owner[d]]) begin
        m_granted[d] = 1'b0;
        m_prev[d]    = m_owner[d];
      end
    end
  endtask

  task automatic pack_words();
    for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = words[i];
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) words[i] = 16'(16'h0300 - 16'(i) * 16'h0100);
    pack_words();
    model_reset();
    repeat (2) @(posedge clock);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock);
      // Sticky valids give long bursts; occasional drops exercise early release.
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) begin
        if (c < 40) req_valid[i] = (i == 0) || (c >= 20);
        else if ($urandom_range(0, 9) == 0) req_valid[i] = ~req_valid[i];
        words[i] = 16'($urandom);
      end
      pack_words();
      out_ready = (c < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      check_outputs();
      if (reset) model_reset();
      else model_advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
